count_comparator: RTL
=====================

# count_comparator

Compare stage that sits directly downstream of the 8-bit up/down `Counter` in the Comparador design and consumes its `count` output. It holds a programmable threshold and produces registered less-than, equal and greater-than flags. An armed match detector issues one pulse per threshold match, and a sticky flag plus a saturating match counter record the events for the rest of the design.

## Interface
- `WIDTH`, 8: width of `count`, `cmp_value` and the internal threshold.
- `CNT_W`, 4: width of `match_cnt`.
- `HYST`, 2: hysteresis distance in counts. Used only when `CMP_HYST_EN` is defined.

- `clk` in 1: the single clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `count` in WIDTH: current value from the upstream `Counter`.
- `cmp_load` in 1: when high, `cmp_value` is captured into the threshold register.
- `cmp_value` in WIDTH: new threshold value.
- `arm` in 1: level input that enables the match detector.
- `clear` in 1: one-cycle clear of `match_flag` and `match_cnt`.
- `lt`, `eq`, `gt` out 1 each: registered result of comparing `count` with the threshold.
- `match_pulse` out 1: one-cycle pulse per detected match.
- `match_flag` out 1: sticky; set on every match.
- `match_cnt` out CNT_W: number of matches, saturating.
- `state` out 2: FSM state. IDLE=0, ARMED=1, MATCHED=2, HOLD=3.

## Operation
- Stage 1 (compare), every edge:
  - `lt`, `eq`, `gt` are computed from `count` and the threshold as it stood before that edge.
  - Exactly one of the three is high after the first post-reset edge.
  - Comparison is unsigned.
- Threshold load: `cmp_load` updates the threshold at the edge.
  - A comparison made on the same edge uses the old threshold.
- Stage 2 (FSM):
  - IDLE → ARMED when `arm`=1.
  - ARMED → MATCHED when `eq`=1.
  - MATCHED → HOLD unconditionally.
  - HOLD → ARMED when the release condition holds (see Configuration).
  - `arm`=0 in any state → IDLE on the next edge. This takes priority over all other transitions.
- `match_pulse` equals (`state`==MATCHED), decoded from the state register.
- On the edge entering MATCHED:
  - `match_flag` is set to 1.
  - `match_cnt` increments, saturating at 2^CNT_W−1.
- `clear` takes priority over a simultaneous entry into MATCHED:
  - `match_flag` goes to 0 and `match_cnt` goes to 0.
  - The FSM still enters MATCHED and `match_pulse` still fires.
- If the threshold changes while in HOLD, the release condition is evaluated against the new threshold.
- The upstream counter's wrap (e.g. 99→0) is treated as an ordinary value change. No special handling.

## Timing
- Reset values: `lt`=`eq`=`gt`=0, threshold=0, `state`=IDLE, `match_pulse`=0, `match_flag`=0, `match_cnt`=0.
- `rst` mid-operation forces all of the above on the next edge, regardless of `arm`, `clear` or `cmp_load`.
- Latency, with `count`==threshold sampled at edge k:
  - `eq` is high after edge k.
  - The FSM enters MATCHED at edge k+1, so `match_pulse` is high for cycle k+1..k+2.
  - `match_flag` and `match_cnt` are updated after edge k+1.
- A threshold load at edge j affects `lt`/`eq`/`gt` from edge j+1 onward.
- A constant `count` equal to the threshold yields exactly one pulse. The FSM remains in HOLD.

## Configuration
- `CMP_HYST_EN` undefined: HOLD releases when `eq`=0, i.e. any one-count departure from the threshold.
- `CMP_HYST_EN` defined:
  - An extra registered distance |`count` − threshold| is computed in WIDTH+1 bits with no wrap.
  - HOLD releases only when the distance is greater than `HYST`.
  - The release decision is made one edge later than without the macro.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `arm`=1 and `count`=0 → all outputs 0 and `state`=IDLE. The first edge after release gives `eq`=1, since the threshold is 0.
- Basic match: load `cmp_value`=85, `arm`=1, `count` ramps 80..90 one step per cycle → `eq` is high one edge after 85 is sampled. Then:
  - `match_pulse` is high for exactly one cycle, two edges after 85 is sampled.
  - `match_cnt`=1 and `match_flag`=1.
  - `gt`=1 from 86 onward.
- Hold/re-match: `count` sequence 85×5, then 86, then 85 →
  - Without `CMP_HYST_EN`: one pulse for the 85×5 run, a second on the return to 85, `match_cnt`=2.
  - With `CMP_HYST_EN` and `HYST`=2: no second pulse. The sequence 85..88, 85 then gives the second pulse.
- Saturation: `CNT_W`=4, 20 separate matches → `match_cnt` stops at 15 and `match_flag`=1.
- Clear collision: `clear`=1 on the edge entering MATCHED → `match_pulse` fires, `match_flag`=0, `match_cnt`=0.
- Abort paths:
  - `arm`=0 while ARMED with `eq` pending → IDLE and no pulse.
  - `rst`=1 while in HOLD → IDLE with all outputs 0 after one edge.

Source files
------------

// File: rtl/count_comparator.sv
// count_comparator: registered threshold compare with an armed, one-shot match detector.
// Optional feature: define CMP_HYST_EN to release HOLD only once |count - threshold| > HYST.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   count               value from the upstream counter
//   cmp_load, cmp_value threshold load strobe and value
//   arm                 level enable for the match detector
//   clear               one-cycle clear of match_flag / match_cnt
//   lt, eq, gt          registered unsigned compare of count against the threshold
//   match_pulse         high while the FSM sits in MATCHED
//   match_flag          sticky match indicator
//   match_cnt           saturating match counter
//   state               FSM state (IDLE=0, ARMED=1, MATCHED=2, HOLD=3)
module count_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int HYST  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             cmp_load,
    input  logic [WIDTH-1:0] cmp_value,
    input  logic             arm,
    input  logic             clear,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             match_pulse,
    output logic             match_flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE, ARMED, MATCHED, HOLD} state_t;
    state_t           st, nxt;
    logic [WIDTH-1:0] thr;
    logic             release_ok;
    logic             enter;
    // Compare stage uses the threshold as it stood before the edge, so a
    // same-edge load only takes effect on the following comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr <= '0;
            lt  <= 1'b0;
            eq  <= 1'b0;
            gt  <= 1'b0;
        end else begin
            thr <= cmp_load ? cmp_value : thr;
            lt  <= count < thr;
            eq  <= count == thr;
            gt  <= count > thr;
        end
    end
`ifdef CMP_HYST_EN
    logic [WIDTH:0] dist;
    logic           far;
    // Distance is computed one bit wider so it never wraps; the extra
    // register stage on far delays the release decision by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dist <= '0;
            far  <= 1'b0;
        end else begin
            dist <= count >= thr ? {1'b0, count} - {1'b0, thr} : {1'b0, thr} - {1'b0, count};
            far  <= dist > (WIDTH+1)'(HYST);
        end
    end
    assign release_ok = far;
`else
    assign release_ok = !eq;
`endif
    // Dropping arm returns to IDLE from any state ahead of every other transition.
    always_comb begin
        nxt = !arm           ? IDLE :
              st == IDLE     ? ARMED :
              st == ARMED    ? (eq ? MATCHED : ARMED) :
              st == MATCHED  ? HOLD :
                               (release_ok ? ARMED : HOLD);
        enter = st == ARMED && nxt == MATCHED;
    end
    // clear wins over a simultaneous match, but the FSM still advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            match_flag <= 1'b0;
            match_cnt  <= '0;
        end else begin
            st         <= nxt;
            match_flag <= clear ? 1'b0 : (enter ? 1'b1 : match_flag);
            match_cnt  <= clear ? '0 : (enter && match_cnt != '1 ? match_cnt + 1'b1 : match_cnt);
        end
    end
    assign match_pulse = st == MATCHED;
    assign state       = st;
endmodule
